// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding,
// register-index type and PC mux select values.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    LDSTALL = 3'd1,
    MEMWAIT = 3'd2,
    REDIR   = 3'd3,
    HALT    = 3'd4
  } pipe_ctrl_state_t;

  typedef logic [4:0] regbits_t;

  localparam logic [1:0] PCSEL_NPC = 2'd0;
  localparam int unsigned LDCNT_W  = 2;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// source registers of the instruction sitting in IF/ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  regbits_t id_rs_i,
  input  regbits_t id_rt_i,
  input  logic     ex_dren_i,
  input  regbits_t ex_wsel_i,
  output logic     hz_o
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign hz_o = ex_dren_i && (ex_wsel_i != '0) &&
                ((ex_wsel_i == id_rs_i) || (ex_wsel_i == id_rt_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipe register / PC sequencing controller. Optional performance counters
// are built when PIPE_PERF_EN is defined; otherwise they read as zero.
module pipe_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LDUSE_STALL = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ihit_i,
  input  logic        dhit_i,
  input  logic        mem_req_i,
  input  regbits_t    id_rs_i,
  input  regbits_t    id_rt_i,
  input  logic        ex_dren_i,
  input  regbits_t    ex_wsel_i,
  input  logic        ex_redir_i,
  input  logic [1:0]  ex_pcsel_i,
  input  logic        ex_halt_i,
  output logic        pc_en_o,
  output logic [1:0]  pc_sel_o,
  output logic        ifid_en_o,
  output logic        ifid_flush_o,
  output logic        idex_en_o,
  output logic        idex_flush_o,
  output logic        halted_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  pipe_ctrl_state_t     state_q, state_d;
  logic [LDCNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           redir_q, redir_d;
  logic                 pend_q, pend_d;
  logic                 hz;
`ifdef PIPE_PERF_EN
  logic                 redir_acc;
`endif

  hazard_detect u_hazard_detect (
    .id_rs_i   (id_rs_i),
    .id_rt_i   (id_rt_i),
    .ex_dren_i (ex_dren_i),
    .ex_wsel_i (ex_wsel_i),
    .hz_o      (hz)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      redir_q <= PCSEL_NPC;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      redir_q <= redir_d;
      pend_q  <= pend_d;
    end
  end

  assign halted_o = (state_q == HALT) && !rst_i;

  always_comb begin
    pc_en_o      = 1'b0;
    pc_sel_o     = PCSEL_NPC;
    ifid_en_o    = 1'b0;
    ifid_flush_o = 1'b0;
    idex_en_o    = 1'b0;
    idex_flush_o = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    redir_d      = redir_q;
    pend_d       = pend_q;
`ifdef PIPE_PERF_EN
    redir_acc    = 1'b0;
`endif
    if (!rst_i) begin
      unique case (state_q)
        HALT: ;
        MEMWAIT: begin
          if (ex_halt_i)   state_d = HALT;
          else if (dhit_i) state_d = pend_q ? REDIR : RUN;
        end
        RUN, LDSTALL, REDIR: begin
          if (ex_halt_i) begin
            state_d = HALT;
          end else if (mem_req_i && !dhit_i) begin
            state_d = MEMWAIT;
            // EX still holds a bubble in REDIR, so only capture from RUN/LDSTALL
            if (ex_redir_i && state_q != REDIR) begin
              redir_d = ex_pcsel_i;
              pend_d  = 1'b1;
`ifdef PIPE_PERF_EN
              redir_acc = 1'b1;
`endif
            end
          end else if (state_q == REDIR) begin
            pc_sel_o     = redir_q;
            pc_en_o      = ihit_i;
            ifid_en_o    = 1'b1;
            idex_en_o    = 1'b1;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            if (ihit_i) begin
              state_d = RUN;
              pend_d  = 1'b0;
            end
          end else if (ex_redir_i) begin
            redir_d      = ex_pcsel_i;
            pc_sel_o     = ex_pcsel_i;
            pc_en_o      = ihit_i;
            ifid_en_o    = 1'b1;
            idex_en_o    = 1'b1;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            state_d      = ihit_i ? RUN : REDIR;
            pend_d       = !ihit_i;
`ifdef PIPE_PERF_EN
            redir_acc    = 1'b1;
`endif
          end else if (state_q == LDSTALL || hz) begin
            idex_en_o    = 1'b1;
            idex_flush_o = 1'b1;
            if (state_q == LDSTALL) begin
              if (cnt_q <= 1) state_d = RUN;
              else            cnt_d   = cnt_q - 1'b1;
            end else if (LDUSE_STALL > 1) begin
              state_d = LDSTALL;
              cnt_d   = LDCNT_W'(LDUSE_STALL - 1);
            end
          end else begin
            pc_en_o      = ihit_i;
            ifid_en_o    = 1'b1;
            ifid_flush_o = !ihit_i;
            idex_en_o    = 1'b1;
            state_d      = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en_o && !halted_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redir_acc)             flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (LDUSE_STALL=2); counter
// expectations follow whether PIPE_PERF_EN is defined.
module tb_pipe_ctrl;

`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ihit, dhit, mem_req, ex_dren, ex_redir, ex_halt;
  logic [4:0]  id_rs, id_rt, ex_wsel;
  logic [1:0]  ex_pcsel;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, halted;
  logic [1:0]  pc_sel;
  logic [31:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.LDUSE_STALL(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ihit_i       (ihit),
    .dhit_i       (dhit),
    .mem_req_i    (mem_req),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .ex_dren_i    (ex_dren),
    .ex_wsel_i    (ex_wsel),
    .ex_redir_i   (ex_redir),
    .ex_pcsel_i   (ex_pcsel),
    .ex_halt_i    (ex_halt),
    .pc_en_o      (pc_en),
    .pc_sel_o     (pc_sel),
    .ifid_en_o    (ifid_en),
    .ifid_flush_o (ifid_flush),
    .idex_en_o    (idex_en),
    .idex_flush_o (idex_flush),
    .halted_o     (halted),
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_norm(input string tag);
    chk({tag, ".pc_en"},      {31'd0, pc_en},      32'd1);
    chk({tag, ".pc_sel"},     {30'd0, pc_sel},     32'd0);
    chk({tag, ".ifid_en"},    {31'd0, ifid_en},    32'd1);
    chk({tag, ".idex_en"},    {31'd0, idex_en},    32'd1);
    chk({tag, ".ifid_flush"}, {31'd0, ifid_flush}, 32'd0);
    chk({tag, ".idex_flush"}, {31'd0, idex_flush}, 32'd0);
  endtask

  task automatic chk_frozen(input string tag);
    chk({tag, ".pc_en"},      {31'd0, pc_en},      32'd0);
    chk({tag, ".ifid_en"},    {31'd0, ifid_en},    32'd0);
    chk({tag, ".idex_en"},    {31'd0, idex_en},    32'd0);
    chk({tag, ".ifid_flush"}, {31'd0, ifid_flush}, 32'd0);
    chk({tag, ".idex_flush"}, {31'd0, idex_flush}, 32'd0);
  endtask

  task automatic chk_redir(input string tag, input logic [1:0] sel, input logic pce);
    chk({tag, ".pc_sel"},     {30'd0, pc_sel},     {30'd0, sel});
    chk({tag, ".pc_en"},      {31'd0, pc_en},      {31'd0, pce});
    chk({tag, ".ifid_flush"}, {31'd0, ifid_flush}, 32'd1);
    chk({tag, ".idex_flush"}, {31'd0, idex_flush}, 32'd1);
  endtask

  task automatic chk_ldstall(input string tag);
    chk({tag, ".pc_en"},      {31'd0, pc_en},      32'd0);
    chk({tag, ".ifid_en"},    {31'd0, ifid_en},    32'd0);
    chk({tag, ".idex_flush"}, {31'd0, idex_flush}, 32'd1);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] st, input logic [31:0] fl);
    chk({tag, ".stall_cnt"}, stall_cnt, PERF ? st : 32'd0);
    chk({tag, ".flush_cnt"}, flush_cnt, PERF ? fl : 32'd0);
  endtask

  initial begin
    rst = 1'b1; ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0;
    id_rs = '0; id_rt = '0; ex_dren = 1'b0; ex_wsel = '0;
    ex_redir = 1'b0; ex_pcsel = '0; ex_halt = 1'b0;

    // reset cycle: every control output low
    #2;
    chk_frozen("rst");
    chk("rst.halted", {31'd0, halted}, 32'd0);
    tick();
    rst = 1'b0;

    // 1: free-running with hits
    for (int i = 0; i < 10; i++) begin
      #1; chk_norm("run"); tick();
    end
    chk_cnt("run.cnt", 32'd0, 32'd0);
    ihit = 1'b0;
    #1;
    chk("miss.pc_en",      {31'd0, pc_en},      32'd0);
    chk("miss.ifid_flush", {31'd0, ifid_flush}, 32'd1);
    chk("miss.idex_en",    {31'd0, idex_en},    32'd1);
    tick();
    ihit = 1'b1;

    // 2: load-use on rt, two bubble cycles
    ex_dren = 1'b1; ex_wsel = 5'd5; id_rt = 5'd5; id_rs = 5'd3;
    #1; chk_ldstall("lu0"); tick();
    ex_dren = 1'b0;
    #1; chk_ldstall("lu1"); tick();
    #1; chk_norm("lu_done"); tick();
    ex_dren = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1; chk_norm("lu_r0"); tick();
    ex_dren = 1'b0;
    chk_cnt("lu.cnt", 32'd3, 32'd0);

    // 3: redirect across three I-cache miss cycles
    ex_redir = 1'b1; ex_pcsel = 2'd2; ihit = 1'b0;
    #1; chk_redir("rd0", 2'd2, 1'b0); tick();
    ex_redir = 1'b0; ex_pcsel = 2'd0;
    #1; chk_redir("rd1", 2'd2, 1'b0); tick();
    #1; chk_redir("rd2", 2'd2, 1'b0); tick();
    ihit = 1'b1;
    #1; chk_redir("rd3", 2'd2, 1'b1); tick();
    #1; chk_norm("rd_done"); tick();
    chk_cnt("rd.cnt", 32'd6, 32'd1);

    // 4: D-mem wait with a redirect latched in its first cycle
    mem_req = 1'b1; dhit = 1'b0; ex_redir = 1'b1; ex_pcsel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      #1; chk_frozen("mw"); tick();
      ex_redir = 1'b0; ex_pcsel = 2'd0;
    end
    dhit = 1'b1;
    tick();
    mem_req = 1'b0; dhit = 1'b0;
    #1; chk_redir("mw_redir", 2'd1, 1'b1); tick();
    #1; chk_norm("mw_done"); tick();
    chk_cnt("mw.cnt", 32'd11, 32'd2);

    // 5: redirect beats a simultaneous load-use
    ex_redir = 1'b1; ex_pcsel = 2'd3; ex_dren = 1'b1; ex_wsel = 5'd5; id_rt = 5'd5;
    #1;
    chk_redir("rl", 2'd3, 1'b1);
    chk("rl.ifid_en", {31'd0, ifid_en}, 32'd1);
    tick();
    ex_redir = 1'b0; ex_pcsel = 2'd0; ex_dren = 1'b0; ex_wsel = 5'd0; id_rt = 5'd0;
    #1; chk_norm("rl_done"); tick();
    chk_cnt("rl.cnt", 32'd11, 32'd3);

    // 6: halt is sticky until reset
    ex_halt = 1'b1;
    #1; chk("halt0.pc_en", {31'd0, pc_en}, 32'd0); tick();
    ex_halt = 1'b0; ex_redir = 1'b1; ex_pcsel = 2'd2; ihit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk_frozen("halt");
      chk("halt.halted", {31'd0, halted}, 32'd1);
      tick();
    end
    chk_cnt("halt.cnt", 32'd12, 32'd3);
    rst = 1'b1; ex_redir = 1'b0; ex_pcsel = 2'd0;
    #1;
    chk_frozen("rst2");
    chk("rst2.halted", {31'd0, halted}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk_norm("post_rst");
    chk_cnt("post_rst.cnt", 32'd0, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
